// File: rtl/add_10.sv
// Registered unsigned adder: {c,s} = a + b through an explicit ripple-carry
// chain of full-adder cells, with one output register stage.

module add_10_fa (
  input  logic a,
  input  logic b,
  input  logic k_in,
  output logic s,
  output logic k_out
);
  assign s     = a ^ b ^ k_in;
  assign k_out = (a & b) | (a & k_in) | (b & k_in);
endmodule

// Handshake: in_valid high at a rising edge captures a/b; the result appears on
// s/c after that edge with out_valid high for exactly that one cycle. There is
// no ready/backpressure, so a new operand pair may be presented on every edge.
module add_10 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             out_valid
);

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum_w;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             out_valid_d, out_valid_q;

  assign k[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    add_10_fa u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .k_in  (k[i]),
      .s     (sum_w[i]),
      .k_out (k[i+1])
    );
  end

  // Outputs hold while idle so a/b (even undriven) never reach s/c.
  always_comb begin
    s_d         = s_q;
    c_d         = c_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum_w;
      c_d         = k[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q         <= '0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign c         = c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_10.sv
// Bench for add_10: directed vectors, expected {c,s} queued at issue time and
// checked by an independent monitor whenever out_valid is seen.

module tb_add_10;

  localparam int W = 9;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s;
  logic         c;
  logic         out_valid;

  logic [W:0] exp_q[$];
  int tests;
  int fails;
  bit done;

  add_10 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .c         (c),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {ov,c,s}=%b_%b_%h expected %b_%b_%h", name,
               act[W+1], act[W], act[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [W:0] e;
    while (!done) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: out_valid with s=%h c=%b but nothing expected", s, c);
        end else begin
          e = exp_q.pop_front();
          check("result", {1'b1, c, s}, {1'b1, e});
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    exp_q.push_back({ec, es});
  endtask

  task automatic idle(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{9'h000, 9'h00A, 9'h00A, 1'b0};
    vecs[1] = '{9'h1F8, 9'h007, 9'h1FF, 1'b0};
    vecs[2] = '{9'h100, 9'h100, 9'h000, 1'b1};
    vecs[3] = '{9'h100, 9'h100, 9'h000, 1'b1};
    vecs[4] = '{9'h1F0, 9'h010, 9'h000, 1'b1};
    vecs[5] = '{9'h0F0, 9'h010, 9'h100, 1'b0};
    vecs[6] = '{9'h1FF, 9'h001, 9'h000, 1'b1};
    vecs[7] = '{9'h155, 9'h0AA, 9'h1FF, 1'b0};
    vecs[8] = '{9'h1FF, 9'h1FF, 9'h1FE, 1'b1};
    vecs[9] = '{9'h170, 9'h110, 9'h080, 1'b1};

    done     = 1'b0;
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, c, s}, '0);
    reset = 1'b0;

    // back-to-back vectors, one per cycle
    foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);

    // idle with new operands: last result must hold, out_valid low
    idle(9'h055, 9'h0AA);
    @(negedge clk);
    check("hold_1", {out_valid, c, s}, {1'b0, 1'b1, 9'h080});
    a = 9'h1FF;
    b = 9'h1FF;
    @(negedge clk);
    check("hold_2", {out_valid, c, s}, {1'b0, 1'b1, 9'h080});

    // reset mid-stream while a second operand pair is being presented
    drive(9'h0C0, 9'h0C0, 9'h180, 1'b0);
    @(negedge clk);
    a        = 9'h1F0;
    b        = 9'h020;
    in_valid = 1'b1;
    #1 reset = 1'b1;
    #1 check("reset_async", {out_valid, c, s}, '0);
    @(negedge clk);
    check("reset_held", {out_valid, c, s}, '0);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    reset    = 1'b0;
    @(negedge clk);
    check("no_x_after_reset", {out_valid, c, s}, '0);

    drive(9'h0FF, 9'h001, 9'h100, 1'b0);
    idle(9'h000, 9'h000);
    @(negedge clk);
    check("post_reset_idle", {out_valid, c, s}, {1'b0, 1'b0, 9'h100});

    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still expected, required 0", exp_q.size());
    end
    done = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
